// File: rtl/local_maxima_pkg.sv
// Shared types and defaults for the local-maxima peak collector.
// Holds the FSM encoding and the default index width / FIFO depth.
package local_maxima_pkg;

    localparam int IDX_W_DEF = 8;
    localparam int DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/local_maxima_peak_fifo.sv
// Peak-index FIFO: flop storage, full/empty flags, same-cycle push/pop.
// A push into a full FIFO is taken only when a pop frees the slot that cycle.
module local_maxima_peak_fifo
    import local_maxima_pkg::*;
#(
    parameter int W     = IDX_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         rd_ready,
    output logic         rd_valid,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign rd_valid = !empty;
    // Empty (and therefore reset) forces a zero index onto the output.
    assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = rd_valid && rd_ready;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/local_maxima_collector.sv
// Collects sample indices of detector peaks into a FIFO and drains them
// after end-of-stream; counts all peaks and flags any that were dropped.
module local_maxima_collector
    import local_maxima_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             peak_in,
    input  logic             finish_in,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [IDX_W-1:0] rd_idx,
    output logic [IDX_W:0]   peak_count,
    output logic             overflow,
    output logic             done
);

    localparam int PC_W = IDX_W + 1;
    localparam logic [PC_W-1:0] PC_MAX = '1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             ovf_q, ovf_d;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;

    assign pop        = rd_valid && rd_ready;
    assign peak_count = pc_q;
    assign overflow   = ovf_q;
    assign done       = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pc_d    = pc_q;
        ovf_d   = ovf_q;
        push    = 1'b0;
        unique case (state_q)
            COLLECT: begin
                if (en) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (peak_in) begin
                        push = 1'b1;
                        if (pc_q != PC_MAX) begin
                            pc_d = pc_q + PC_W'(1);
                        end
                        if (fifo_full && !pop) begin
                            ovf_d = 1'b1;
                        end
                    end
                end
                if (finish_in) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            pc_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pc_q    <= pc_d;
            ovf_q   <= ovf_d;
        end
    end

    local_maxima_peak_fifo #(
        .W     (IDX_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .wr_data  (idx_q),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_idx),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: doc/local_maxima_collector.md
LOCAL_MAXIMA_COLLECTOR -- requirements
Module: local_maxima_collector

Interface
REQ-001 SHALL have parameter IDX_W, default 8, width of sample index and stored peak index.
REQ-002 SHALL have parameter DEPTH, default 16, number of peak-index FIFO entries (power of two).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  sample strobe from the detector; one sample per high cycle.
REQ-006 SHALL have port peak_in  input  1  detector flag; the current sample is a local maximum; qualified by en.
REQ-007 SHALL have port finish_in  input  1  detector end-of-stream indication.
REQ-008 SHALL have port rd_ready  input  1  downstream ready for peak index.
REQ-009 SHALL have port rd_valid  output  1  rd_idx holds a valid stored peak index.
REQ-010 SHALL have port rd_idx  output  IDX_W  oldest stored peak index.
REQ-011 SHALL have port peak_count  output  IDX_W+1  total peaks detected since reset, stored or dropped.
REQ-012 SHALL have port overflow  output  1  sticky; at least one peak dropped because the FIFO was full.
REQ-013 SHALL have port done  output  1  stream finished and all stored indices read out.

Function
REQ-014 SHALL implement the FSM states COLLECT, DRAIN and DONE; reset state SHALL be COLLECT.
REQ-015 In COLLECT, each cycle with en=1 SHALL increment the sample index counter, which starts at 0 and wraps modulo 2^IDX_W.
REQ-016 The index stored for a sample SHALL be the counter value before that sample's increment, so the first sample is index 0.
REQ-017 In COLLECT, en=1 with peak_in=1 SHALL push the sample index into the FIFO and increment peak_count.
REQ-018 peak_count SHALL saturate at 2^(IDX_W+1)-1.
REQ-019 A push when the FIFO is full and no pop occurs in the same cycle SHALL be dropped, set overflow, and still increment peak_count.
REQ-020 A pop SHALL occur on a cycle with rd_valid=1 and rd_ready=1; rd_valid SHALL equal FIFO not-empty, in every state.
REQ-021 Simultaneous push and pop on a full FIFO SHALL accept the push; occupancy is unchanged and overflow is not set.
REQ-022 Simultaneous push and pop on a one-entry FIFO SHALL pop the old entry and store the new one.
REQ-023 Push-to-rd_valid latency SHALL be 1 cycle.
REQ-024 rd_idx SHALL stay stable while rd_valid=1 and rd_ready=0.
REQ-025 finish_in=1 in COLLECT SHALL move to DRAIN next cycle; a sample presented in the same cycle as finish_in SHALL still be processed.
REQ-026 In DRAIN and DONE, en, peak_in and finish_in SHALL be ignored.
REQ-027 DRAIN SHALL move to DONE on the cycle after the FIFO becomes empty (including immediately if it is already empty).
REQ-028 done SHALL be 1 only in DONE.
REQ-029 DONE SHALL be held until reset.

Reset
REQ-030 rst=0 SHALL asynchronously clear the FSM to COLLECT, the index counter, FIFO pointers and occupancy, peak_count, overflow and done.
REQ-031 During reset, rd_valid SHALL be 0 and rd_idx SHALL be 0.
REQ-032 Reset asserted mid-stream or mid-drain SHALL discard all stored indices with no partial pop.
REQ-033 Operation SHALL resume on the first rising edge after rst returns high.

Structure
REQ-034 The FSM state encoding and the default IDX_W and DEPTH SHALL reside in shared package local_maxima_pkg.
REQ-035 The FIFO SHALL be sub-module local_maxima_peak_fifo: synchronous, registered output, with full/empty flags and the same-cycle push/pop rules of REQ-021 and REQ-022.
REQ-036 The top level SHALL contain only the FSM, the index counter, peak_count and overflow logic.

Verification
REQ-037 Scenario 1: 8 samples with peak_in=1 at samples 1, 3 and 7, rd_ready=1, then finish_in -> rd_idx 1, 3, 7 in order; peak_count=3; done=1 two cycles after the last pop.
REQ-038 Scenario 2: rd_ready=0, 20 consecutive peaks with DEPTH=16 -> overflow=1, peak_count=20; draining yields indices 0..15.
REQ-039 Scenario 3: full FIFO with push and pop in the same cycle -> overflow stays 0 and the new index is the last one read.
REQ-040 Scenario 4: 300 samples with a peak at sample 260 -> stored index 4 (wrap); peak_count=1.
REQ-041 Scenario 5: rst pulsed low for 3 ns between clock edges during DRAIN with 5 entries stored -> rd_valid=0, done=0, peak_count=0 immediately; a new stream then collects from index 0.
REQ-042 Scenario 6: finish_in, en and peak_in all high on sample 0 with the FIFO empty -> index 0 stored; DRAIN; after the single pop, done=1.
